fetch_ctrl_v2: RTL and testbench

//  Parametrised next-generation instruction fetch / PC controller for the MCU core.

---
 rtl/fetch_ctrl_v2_if.sv | 47 ++++
 rtl/fetch_ctrl_v2.sv | 133 +++++++++++++
 tb/tb_fetch_ctrl_v2.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_v2_if.sv
// rtl/fetch_ctrl_v2_if.sv - fetch controller bus bundle (core controls, memory data, fetch outputs)
// Ports grouped here:
//   master (core/stimulus side): drives mcu_en, pc_start, rom_dout, ram_dout, call/return/jmp/hold
//                                controls; observes pc_final, inst2decoder, ce_rom, ce_ram,
//                                stack_level, stk_ovf, stk_unf, fault
//   slave  (fetch_ctrl_v2):      the mirror image of master
interface fetch_ctrl_v2_if #(
  parameter int PC_W        = 16,
  parameter int INST_W      = 20,
  parameter int STACK_DEPTH = 3
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              mcu_en;
  logic [PC_W-1:0]   pc_start;
  logic [INST_W-1:0] rom_dout;
  logic [INST_W-1:0] ram_dout;
  logic              call_en;
  logic [PC_W-1:0]   call_const;
  logic              return_en;
  logic              jmp_en;
  logic [PC_W-1:0]   jmp_const;
  logic              pc_hold;

  logic [PC_W-1:0]   pc_final;
  logic [INST_W-1:0] inst2decoder;
  logic              ce_rom;
  logic              ce_ram;
  logic [SP_W-1:0]   stack_level;
  logic              stk_ovf;
  logic              stk_unf;
  logic              fault;

  modport master (
    output mcu_en, pc_start, rom_dout, ram_dout, call_en, call_const,
           return_en, jmp_en, jmp_const, pc_hold,
    input  pc_final, inst2decoder, ce_rom, ce_ram, stack_level,
           stk_ovf, stk_unf, fault
  );

  modport slave (
    input  mcu_en, pc_start, rom_dout, ram_dout, call_en, call_const,
           return_en, jmp_en, jmp_const, pc_hold,
    output pc_final, inst2decoder, ce_rom, ce_ram, stack_level,
           stk_ovf, stk_unf, fault
  );
endinterface

// File: rtl/fetch_ctrl_v2.sv
// rtl/fetch_ctrl_v2.sv - instruction fetch / PC controller with call stack and RUN/IDLE/FAULT sequencing
// Ports:
//   clk  in  core clock, all state on rising edge
//   rst  in  asynchronous active-high reset
//   bus  fetch_ctrl_v2_if.slave: core controls and memory read data in; fetch address,
//        decoder instruction, ROM/RAM chip enables, stack level and fault flags out
module fetch_ctrl_v2 #(
  parameter int PC_W        = 16,
  parameter int INST_W      = 20,
  parameter int STACK_DEPTH = 3
) (
  input  logic           clk,
  input  logic           rst,
  fetch_ctrl_v2_if.slave bus
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              mcu_en_d;
  logic              push;
  logic [PC_W-1:0]   top_data;
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];

  // Only the rising edge of mcu_en restarts the core.
  logic start;
  assign start = bus.mcu_en & ~mcu_en_d;

  // Top-of-stack read, resolved combinationally so a return needs no bubble.
  always_comb begin
    top_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (SP_W'(i) == level_q - SP_W'(1)) top_data = stack_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (start) begin
      state_d = ST_RUN;
      pc_d    = bus.pc_start;
      level_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          // Dropping mcu_en beats any control, so a call/return in that cycle leaves the stack alone.
          if (!bus.mcu_en) begin
            state_d = ST_IDLE;
          end else if (bus.call_en) begin
            if (level_q < SP_W'(STACK_DEPTH)) begin
              push    = 1'b1;
              level_d = level_q + SP_W'(1);
              pc_d    = bus.call_const;
            end else begin
              ovf_d   = 1'b1;
              state_d = ST_FAULT;
            end
          end else if (bus.return_en) begin
            if (level_q != '0) begin
              pc_d    = top_data;
              level_d = level_q - SP_W'(1);
            end else begin
              unf_d   = 1'b1;
              state_d = ST_FAULT;
            end
          end else if (bus.jmp_en) begin
            pc_d = bus.jmp_const;
          end else if (!bus.pc_hold) begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        ST_FAULT: if (!bus.mcu_en) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      mcu_en_d <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      mcu_en_d <= bus.mcu_en;
    end
  end

  // The pushed address is the current pc_final, which already points past the call
  // because memory read data lags the address by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (SP_W'(i) == level_q) stack_q[i] <= pc_q;
      end
    end
  end

  assign bus.pc_final     = pc_q;
  assign bus.inst2decoder = pc_q[PC_W-1] ? bus.ram_dout : bus.rom_dout;
  assign bus.ce_rom       = (state_q == ST_RUN) & ~pc_q[PC_W-1];
  assign bus.ce_ram       = (state_q == ST_RUN) &  pc_q[PC_W-1];
  assign bus.stack_level  = level_q;
  assign bus.stk_ovf      = ovf_q;
  assign bus.stk_unf      = unf_q;
  assign bus.fault        = (state_q == ST_FAULT);
endmodule

// File: tb/tb_fetch_ctrl_v2.sv
// tb/tb_fetch_ctrl_v2.sv - randomized and directed bench for fetch_ctrl_v2 against a queue-based model
module tb_fetch_ctrl_v2;
  localparam int PC_W   = 16;
  localparam int INST_W = 20;
  localparam int DEPTH  = 3;
  localparam int PC_MOD = 1 << PC_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_v2_if #(.PC_W(PC_W), .INST_W(INST_W), .STACK_DEPTH(DEPTH)) bus ();

  fetch_ctrl_v2 #(.PC_W(PC_W), .INST_W(INST_W), .STACK_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0=idle 1=run 2=fault, stack as a queue of return addresses.
  int          m_mode;
  int unsigned m_pc;
  int unsigned m_stk[$];
  bit          m_ovf, m_unf, m_en_d;
  logic [INST_W-1:0] r_rom, r_ram;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_en_d = 0;
  endtask

  task automatic model_step();
    bit en;
    en = bus.mcu_en;
    if (en && !m_en_d) begin
      m_mode = 1; m_pc = bus.pc_start; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_mode == 1) begin
      if (!en) m_mode = 0;
      else if (bus.call_en) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back(m_pc);
          m_pc = bus.call_const;
        end else begin
          m_ovf = 1; m_mode = 2;
        end
      end else if (bus.return_en) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_unf = 1; m_mode = 2;
        end
      end else if (bus.jmp_en) m_pc = bus.jmp_const;
      else if (!bus.pc_hold) m_pc = (m_pc + 1) % PC_MOD;
    end else if (m_mode == 2) begin
      if (!en) m_mode = 0;
    end
    m_en_d = en;
  endtask

  task automatic compare_all();
    bit msb;
    msb = ((m_pc >> (PC_W - 1)) & 1) != 0;
    chk("pc_final",    32'(bus.pc_final),     32'(m_pc));
    chk("stack_level", 32'(bus.stack_level),  32'(m_stk.size()));
    chk("stk_ovf",     32'(bus.stk_ovf),      32'(m_ovf));
    chk("stk_unf",     32'(bus.stk_unf),      32'(m_unf));
    chk("fault",       32'(bus.fault),        32'(m_mode == 2));
    chk("ce_rom",      32'(bus.ce_rom),       32'(m_mode == 1 && !msb));
    chk("ce_ram",      32'(bus.ce_ram),       32'(m_mode == 1 && msb));
    chk("inst2decoder", 32'(bus.inst2decoder), 32'(msb ? r_ram : r_rom));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    r_rom = INST_W'($urandom);
    r_ram = INST_W'($urandom);
    bus.rom_dout = r_rom;
    bus.ram_dout = r_ram;
    #1;
    compare_all();
  endtask

  task automatic drive(input bit en, input bit c, input bit r, input bit j, input bit h);
    bus.mcu_en = en; bus.call_en = c; bus.return_en = r; bus.jmp_en = j; bus.pc_hold = h;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    bus.pc_start = '0; bus.call_const = '0; bus.jmp_const = '0;
    r_rom = 20'h12345; r_ram = 20'hABCDE;
    bus.rom_dout = r_rom; bus.ram_dout = r_ram;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk) rst = 1'b0;

    // 1: start at 0x0010 then sequential fetch from ROM
    bus.pc_start = 16'h0010; drive(1, 0, 0, 0, 0);
    cycle();
    chk("t1_start_pc", 32'(bus.pc_final), 32'h10);
    repeat (4) cycle();
    chk("t1_pc_after4", 32'(bus.pc_final), 32'h14);
    chk("t1_ce_rom", 32'(bus.ce_rom), 32'h1);

    // 2: restart in RAM space, then jump back to ROM
    drive(0, 0, 0, 0, 0); cycle();
    bus.pc_start = 16'h8000; drive(1, 0, 0, 0, 0); cycle();
    chk("t2_ce_ram", 32'(bus.ce_ram), 32'h1);
    chk("t2_ce_rom", 32'(bus.ce_rom), 32'h0);
    chk("t2_inst_ram", 32'(bus.inst2decoder), 32'(r_ram));
    bus.jmp_const = 16'h0005; drive(1, 0, 0, 1, 0); cycle();
    chk("t2_jmp_ce_rom", 32'(bus.ce_rom), 32'h1);

    // 3: nested call/return
    bus.jmp_const = 16'h0020; cycle();
    bus.call_const = 16'h0100; drive(1, 1, 0, 0, 0); cycle();
    drive(1, 0, 0, 0, 0); cycle();
    bus.call_const = 16'h0200; drive(1, 1, 0, 0, 0); cycle();
    chk("t3_level2", 32'(bus.stack_level), 32'h2);
    drive(1, 0, 1, 0, 0); cycle();
    chk("t3_ret1_pc", 32'(bus.pc_final), 32'h101);
    drive(1, 0, 0, 0, 0); cycle();
    chk("t3_pc_102", 32'(bus.pc_final), 32'h102);
    drive(1, 0, 1, 0, 0); cycle();
    drive(1, 0, 0, 0, 0); cycle();
    chk("t3_pc_21", 32'(bus.pc_final), 32'h21);
    chk("t3_level0", 32'(bus.stack_level), 32'h0);

    // 4: overflow on the fourth call, recovery through mcu_en toggle
    for (int i = 0; i < 4; i++) begin
      bus.call_const = 16'(16'h0300 + 16 * i); drive(1, 1, 0, 0, 0); cycle();
    end
    chk("t4_ovf", 32'(bus.stk_ovf), 32'h1);
    chk("t4_fault", 32'(bus.fault), 32'h1);
    chk("t4_pc_frozen", 32'(bus.pc_final), 32'h320);
    drive(1, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0); cycle();
    bus.pc_start = 16'h0040; drive(1, 0, 0, 0, 0); cycle();
    chk("t4_ovf_clear", 32'(bus.stk_ovf), 32'h0);

    // 5: underflow, then simultaneous call/return/jump takes the call
    drive(1, 0, 1, 0, 0); cycle();
    chk("t5_unf", 32'(bus.stk_unf), 32'h1);
    drive(0, 0, 0, 0, 0); cycle();
    bus.pc_start = 16'h0050; drive(1, 0, 0, 0, 0); cycle();
    bus.call_const = 16'h0400; bus.jmp_const = 16'h0600; drive(1, 1, 1, 1, 1); cycle();
    chk("t5_call_wins", 32'(bus.pc_final), 32'h400);

    // 6: wrap, hold, async reset without a clock edge
    bus.jmp_const = 16'hFFFF; drive(1, 0, 0, 1, 0); cycle();
    drive(1, 0, 0, 0, 0); cycle();
    chk("t6_wrap", 32'(bus.pc_final), 32'h0);
    drive(1, 0, 0, 0, 1); repeat (3) cycle();
    chk("t6_hold", 32'(bus.pc_final), 32'h0);
    drive(1, 0, 0, 0, 0); repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t6_async_pc", 32'(bus.pc_final), 32'h0);
    chk("t6_async_level", 32'(bus.stack_level), 32'h0);
    @(negedge clk) rst = 1'b0;
    drive(0, 0, 0, 0, 0); cycle();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      bus.pc_start   = 16'($urandom);
      bus.call_const = 16'($urandom);
      bus.jmp_const  = 16'($urandom);
      drive(($urandom_range(0, 29) != 0), (r < 14), (r >= 10 && r < 26),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
